// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and the
// default chain geometry used by the fabric wrapper and benches.
package ccff_pkg;

    localparam int DEF_BITSTREAM_SIZE = 29696;
    localparam int DEF_WORD_W         = 32;
    localparam int DEF_PROBE_MARGIN   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PROBE  = 2'd2,
        ST_FINISH = 2'd3
    } ccff_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream word stream from the SoC side: valid/ready handshake plus data.
interface ccff_bitstream_loader_if
    import ccff_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/ccff_word_serializer.sv
// Turns accepted bitstream words into a bit stream, MSB first, via a holding
// register feeding a shift register; trims the final partial word.
module ccff_word_serializer
    import ccff_pkg::*;
#(
    parameter int BITSTREAM_SIZE = DEF_BITSTREAM_SIZE,
    parameter int WORD_W         = DEF_WORD_W
) (
    input  logic                   prog_clk,
    input  logic                   pReset,
    input  logic                   clear_i,
    input  logic                   en_i,
    ccff_bitstream_loader_if.slave word_if,
    output logic                   bit_valid_o,
    output logic                   bit_o
);

    localparam int NUM_WORDS = ceil_div(BITSTREAM_SIZE, WORD_W);
    localparam int LAST_BITS = (BITSTREAM_SIZE % WORD_W == 0) ? WORD_W : (BITSTREAM_SIZE % WORD_W);
    localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
    localparam int SCNT_W    = $clog2(WORD_W + 1);

    localparam logic [WCNT_W-1:0] WORDS_TOTAL = WCNT_W'(NUM_WORDS);
    localparam logic [WCNT_W-1:0] WORDS_FINAL = WCNT_W'(NUM_WORDS - 1);
    localparam logic [SCNT_W-1:0] FULL_BITS   = SCNT_W'(WORD_W);
    localparam logic [SCNT_W-1:0] TAIL_BITS   = SCNT_W'(LAST_BITS);

    logic [WORD_W-1:0] hold_q, hold_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              hold_valid_q, hold_valid_d;
    logic              hold_last_q, hold_last_d;
    logic [SCNT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic [WCNT_W-1:0] words_q, words_d;
    logic              accept;

    assign word_if.word_ready = en_i && !hold_valid_q && (words_q < WORDS_TOTAL);
    assign accept             = word_if.word_valid && word_if.word_ready;
    assign bit_valid_o        = en_i && (shift_cnt_q != '0);
    assign bit_o              = shift_q[WORD_W-1];

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        hold_last_d  = hold_last_q;
        shift_d      = shift_q;
        shift_cnt_d  = shift_cnt_q;
        words_d      = words_q;

        if (bit_valid_o) begin
            shift_d     = shift_q << 1;
            shift_cnt_d = shift_cnt_q - SCNT_W'(1);
        end

        // Refill in the same cycle the last bit leaves, so back-to-back words never bubble.
        if (en_i && hold_valid_q && (shift_cnt_d == '0)) begin
            shift_d      = hold_q;
            shift_cnt_d  = hold_last_q ? TAIL_BITS : FULL_BITS;
            hold_valid_d = 1'b0;
        end

        if (accept) begin
            hold_d       = word_if.word_data;
            hold_valid_d = 1'b1;
            hold_last_d  = (words_q == WORDS_FINAL);
            words_d      = words_q + WCNT_W'(1);
        end

        if (clear_i) begin
            hold_d       = '0;
            hold_valid_d = 1'b0;
            hold_last_d  = 1'b0;
            shift_d      = '0;
            shift_cnt_d  = '0;
            words_d      = '0;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            shift_q      <= '0;
            shift_cnt_q  <= '0;
            words_q      <= '0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            hold_last_q  <= hold_last_d;
            shift_q      <= shift_d;
            shift_cnt_q  <= shift_cnt_d;
            words_q      <= words_d;
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain driver: serialises bitstream words onto ccff_head with a
// qualified shift enable, or probes the chain length with a single marker bit.
module ccff_bitstream_loader
    import ccff_pkg::*;
#(
    parameter int  BITSTREAM_SIZE = DEF_BITSTREAM_SIZE,
    parameter int  WORD_W         = DEF_WORD_W,
    parameter int  PROBE_MARGIN   = DEF_PROBE_MARGIN,
    localparam int CNT_W          = $clog2(BITSTREAM_SIZE + PROBE_MARGIN + 1)
) (
    input  logic                   prog_clk,
    input  logic                   pReset,
    input  logic                   start,
    input  logic                   mode_probe,
    ccff_bitstream_loader_if.slave word_if,
    output logic                   ccff_head,
    output logic                   ccff_shift_en,
    input  logic                   ccff_tail,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [CNT_W-1:0]       bit_count
);

    localparam logic [CNT_W-1:0] SIZE_CNT = CNT_W'(BITSTREAM_SIZE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BITSTREAM_SIZE - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(BITSTREAM_SIZE + PROBE_MARGIN);

    ccff_state_e      state_q, state_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic             head_q, head_d;
    logic             shift_en_q, shift_en_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             start_acc;
    logic             ser_valid;
    logic             ser_bit;
    logic             tail_hit;
    logic             probe_end;
    logic             probe_fail;

    assign start_acc  = start && (state_q == ST_IDLE);
    assign tail_hit   = (bit_count_q != '0) && ccff_tail;
    assign probe_end  = tail_hit || (bit_count_q == MAX_CNT);
    assign probe_fail = tail_hit ? (bit_count_q != SIZE_CNT) : 1'b1;

    ccff_word_serializer #(
        .BITSTREAM_SIZE (BITSTREAM_SIZE),
        .WORD_W         (WORD_W)
    ) u_serializer (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .clear_i     (start_acc),
        .en_i        (state_q == ST_LOAD),
        .word_if     (word_if),
        .bit_valid_o (ser_valid),
        .bit_o       (ser_bit)
    );

    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        head_d      = head_q;
        shift_en_d  = 1'b0;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = mode_probe ? ST_PROBE : ST_LOAD;
                    bit_count_d = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                end
            end
            ST_LOAD: begin
                shift_en_d = ser_valid;
                if (ser_valid) begin
                    head_d = ser_bit;
                end
                if (shift_en_q && (bit_count_q != SIZE_CNT)) begin
                    bit_count_d = bit_count_q + CNT_W'(1);
                end
                if (shift_en_q && (bit_count_q == LAST_CNT)) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end
            end
            ST_PROBE: begin
                // The enable for the next edge is already registered when the tail is
                // judged; that trailing edge is not counted, so bit_count reports k.
                if (probe_end) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    error_d = probe_fail;
                    head_d  = 1'b0;
                end else begin
                    shift_en_d = 1'b1;
                    head_d     = (bit_count_q == '0) && !shift_en_q;
                    if (shift_en_q && (bit_count_q != MAX_CNT)) begin
                        bit_count_d = bit_count_q + CNT_W'(1);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q     <= ST_IDLE;
            bit_count_q <= '0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_PROBE);
    assign done          = done_q;
    assign error         = error_q;
    assign bit_count     = bit_count_q;

endmodule
